mips_reg_file: RTL and testbench

//   MIPS general-purpose register file: 2 asynchronous read ports, 1 synchronous write port.

---
 rtl/mips_reg_file.sv | 71 +++++++
 tb/tb_mips_reg_file.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mips_reg_file.sv
// MIPS general-purpose register file: two combinational read ports, one synchronous write port.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module mips_reg_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] w_rd_data1;
    logic [DATA_W-1:0] w_rd_data2;
    logic              w_wr_take;

    // Register 0 is never written, so its storage stays at the reset value of zero.
    assign w_wr_take = wr_en && (wr_addr != {ADDR_W{1'b0}});

    // Storage update: asynchronous clear, otherwise write on posedge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= {DATA_W{1'b0}};
            end
        end else if (w_wr_take) begin
            r_regs[wr_addr] <= wr_data;
        end else begin
            r_regs[wr_addr] <= r_regs[wr_addr];
        end
    end

    // Read port 1 select: address 0 forced to zero, optional forwarding of the pending write.
    always_comb begin
        w_rd_data1 = {DATA_W{1'b0}};
        if (rd_addr1 == {ADDR_W{1'b0}}) begin
            w_rd_data1 = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
        end else if (rst_n && w_wr_take && (wr_addr == rd_addr1)) begin
            w_rd_data1 = wr_data;
`endif
        end else begin
            w_rd_data1 = r_regs[rd_addr1];
        end
    end

    // Read port 2 select: same rules as port 1.
    always_comb begin
        w_rd_data2 = {DATA_W{1'b0}};
        if (rd_addr2 == {ADDR_W{1'b0}}) begin
            w_rd_data2 = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
        end else if (rst_n && w_wr_take && (wr_addr == rd_addr2)) begin
            w_rd_data2 = wr_data;
`endif
        end else begin
            w_rd_data2 = r_regs[rd_addr2];
        end
    end

    assign rd_data1 = w_rd_data1;
    assign rd_data2 = w_rd_data2;

endmodule

// File: tb/tb_mips_reg_file.sv
// Directed self-checking bench for mips_reg_file; expectations follow REGFILE_BYPASS_EN when defined.
module tb_mips_reg_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int checks;
    int errors;

    mips_reg_file dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_pre;
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = 5'd0;
        wr_data  = 32'h0;
        rd_addr1 = 5'd0;
        rd_addr2 = 5'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rd_addr1 = 5'd5;
        rd_addr2 = 5'd31;
        #1;
        check("reset_p1", rd_data1, 32'h0);
        check("reset_p2", rd_data2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1. write r5, then asynchronous reset mid-cycle
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        wr_en = 1'b0;
        #1;
        check("r5_written", rd_data1, 32'hDEADBEEF);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_r5", rd_data1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 2. write r7, read on port 2
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
        rd_addr2 = 5'd7;
        @(posedge clk); #1;
        wr_en = 1'b0;
        rd_addr1 = 5'd8;
        #1;
        check("r7_p2", rd_data2, 32'h12345678);
        check("r8_still_0", rd_data1, 32'h0);

        // 3. writes to r0 discarded
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        rd_addr1 = 5'd0;
        #1;
        check("r0_during_write", rd_data1, 32'h0);
        @(posedge clk); #1;
        wr_en = 1'b0;
        #1;
        check("r0_after_write", rd_data1, 32'h0);

        // 4. wr_en low leaves r3 alone
        @(negedge clk);
        wr_en = 1'b0; wr_addr = 5'd3; wr_data = 32'hAAAA5555;
        rd_addr1 = 5'd3;
        @(posedge clk); #1;
        check("r3_no_write", rd_data1, 32'h0);

        // 5. same-cycle write/read of r9 on both ports
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000BEEF;
        rd_addr1 = 5'd9; rd_addr2 = 5'd9;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 32'h0000BEEF;
`else
        exp_pre = 32'h0;
`endif
        check("r9_pre_p1", rd_data1, exp_pre);
        check("r9_pre_p2", rd_data2, exp_pre);
        @(posedge clk); #1;
        wr_en = 1'b0;
        #1;
        check("r9_post_p1", rd_data1, 32'h0000BEEF);
        check("r9_post_p2", rd_data2, 32'h0000BEEF);

        // Reset asserted across a write edge: clear wins
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hCAFEF00D;
        rd_addr1 = 5'd10; rd_addr2 = 5'd7;
        rst_n = 1'b0;
        #1;
        check("reset_bypass_gated", rd_data1, 32'h0);
        @(posedge clk); #1;
        check("reset_beats_write", rd_data1, 32'h0);
        check("reset_clears_r7", rd_data2, 32'h0);
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("r10_after_release", rd_data1, 32'h0);

        // 6. sweep all registers
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i) * 32'h01010101;
            @(posedge clk);
        end
        @(negedge clk);
        wr_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i);
            rd_addr2 = 5'(31 - i);
            #1;
            check($sformatf("sweep_p1_r%0d", i), rd_data1, 32'(i) * 32'h01010101);
            check($sformatf("sweep_p2_r%0d", 31 - i), rd_data2, 32'(31 - i) * 32'h01010101);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
